hybrid_adder_pipe: RTL and testbench
====================================

HYBRID_ADDER_PIPE -- requirements
Module: hybrid_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 Parameter GROUP, default 4, bits per carry-lookahead group; NGRP = WIDTH/GROUP pipeline stages.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_cin  input  1  carry-in (add mode only).
REQ-010 in_sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_sum  output  WIDTH  result bits.
REQ-014 out_cout  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-015 out_ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Elaboration SHALL fail unless GROUP >= 1 and WIDTH % GROUP == 0.
REQ-017 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-018 Subtract mode: B inverted, group-0 carry-in forced 1, in_cin ignored.
REQ-019 Stage k (k = 0..NGRP-1): computes sum bits [k*GROUP +: GROUP] with GROUP-bit lookahead (P = a^b, G = a&b, every group carry in parallel from P, G, group carry-in).
REQ-020 Group carry-out registered into stage k+1; stage-to-stage carry ripples at one group per cycle.
REQ-021 Unprocessed operand bits and completed sum bits travel with the token; each stage has one valid bit.
REQ-022 Latency: accepted at edge t, no stall -> out_valid high and result on outputs after edge t+NGRP-1.
REQ-023 Throughput: one operation per cycle when out_ready held high.
REQ-024 Stall = out_valid && !out_ready; during stall every stage register and valid bit holds.
REQ-025 in_ready = !stall, combinational; bubbles SHALL NOT be compressed.
REQ-026 out_sum, out_cout, out_ovf SHALL stay stable while out_valid && !out_ready.
REQ-027 out_ovf = carry into MSB XOR carry out of MSB.
REQ-028 out_cout = carry out of bit WIDTH-1; sum wraps modulo 2^WIDTH.
REQ-029 Simultaneous in- and out-transfer in one cycle SHALL be honoured without data loss.
REQ-030 in_valid low: stage-0 valid bit loads 0; other fields don't-care.
REQ-031 Results SHALL leave in acceptance order.

Reset
REQ-032 rst_n low SHALL asynchronously clear all stage valid bits, carries, data registers; out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0.
REQ-033 Reset mid-operation discards all in-flight tokens; none emerge afterward.
REQ-034 First transfer permitted on first rising edge after rst_n deasserts; in_ready = 1 then.

Structure
REQ-035 Package hybrid_adder_pkg: mode constants (MODE_ADD = 0, MODE_SUB = 1) and NGRP derivation function.
REQ-036 One sub-module, cla_group: combinational GROUP-bit lookahead adder (a, b, cin -> sum, cout, carry into MSB), instantiated NGRP times.
REQ-037 Stage registers and handshake live in hybrid_adder_pipe; no other sub-modules.

Verification (WIDTH = 16, GROUP = 4, latency 4 cycles)
REQ-038 Add 0x1234 + 0x4321, cin=0 -> out_sum 0x5555, cout 0, ovf 0, out_valid 4 cycles after acceptance.
REQ-039 Add 0xFFFF + 0x0000, cin=1 -> out_sum 0x0000, cout 1, ovf 0 (full ripple across all groups).
REQ-040 Add 0x7FFF + 0x0001 -> out_sum 0x8000, ovf 1, cout 0; Sub 0x0000 - 0x0001 -> out_sum 0xFFFF, cout 0, ovf 0.
REQ-041 Back-to-back 8 operations, out_ready low for 3 cycles mid-stream -> in_ready low during stall, outputs held, all 8 results in order, none lost or duplicated.
REQ-042 rst_n pulsed low with 3 tokens in flight -> out_valid 0 immediately, no stale result after release, next operation correct at 4-cycle latency.
REQ-043 Random 10k operations both modes vs. reference model: sum, cout, ovf match; scoreboard checks order and latency.

Source files
------------

// File: rtl/hybrid_adder_pkg.sv
// Shared definitions for the hybrid carry-lookahead / carry-ripple pipelined adder.
//   MODE_ADD / MODE_SUB : values of in_sub selecting A+B+cin or A-B.
//   calc_ngrp()         : number of lookahead groups, which is also the number of pipeline stages.
package hybrid_adder_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Returns 0 for a non-positive group size so the caller's own check can report it.
   function automatic int calc_ngrp(input int width, input int group);
      return (group > 0) ? (width / group) : 0;
   endfunction

endpackage

// File: rtl/hybrid_adder_pipe_cla_group.sv
// Combinational W-bit carry-lookahead adder slice.
//   a, b  : operand slices
//   cin   : carry into bit 0 of the slice
//   sum   : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (used for signed overflow)
module cla_group
   import hybrid_adder_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         cmsb
);

   logic [W-1:0] p;
   logic [W-1:0] g;
   logic [W:0]   c;

   assign p = a ^ b;
   assign g = a & b;

   // Each carry is a flat sum of products over P, G and cin, so no carry
   // depends on another carry inside the group.
   always_comb begin
      logic t;
      logic ci;
      t    = 1'b0;
      ci   = 1'b0;
      c    = '0;
      c[0] = cin;
      for (int i = 1; i <= W; i++) begin
         t = cin;
         for (int m = 0; m < i; m++) t = t & p[m];
         ci = t;
         for (int j = 0; j < i; j++) begin
            t = g[j];
            for (int m = j + 1; m < i; m++) t = t & p[m];
            ci = ci | t;
         end
         c[i] = ci;
      end
   end

   assign sum  = p ^ c[W-1:0];
   assign cout = c[W];
   assign cmsb = c[W-1];

endmodule

// File: rtl/hybrid_adder_pipe.sv
// Pipelined adder/subtractor: lookahead inside each GROUP-bit slice, carry
// ripples between slices at one group per clock. Stage k adds group k.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake (in_a, in_b, in_cin, in_sub)
//   out_valid/out_ready   : result handshake (out_sum, out_cout, out_ovf)
// A token accepted at edge t is presented after edge t+NGRP-1. The whole
// pipe freezes while the output is stalled; bubbles are never squeezed out.
module hybrid_adder_pipe
   import hybrid_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NGRP = calc_ngrp(WIDTH, GROUP);

   if (GROUP < 1) begin : g_bad_group
      $error("hybrid_adder_pipe: GROUP must be >= 1");
   end else if (WIDTH % GROUP != 0) begin : g_bad_width
      $error("hybrid_adder_pipe: WIDTH must be a multiple of GROUP");
   end

   logic stall;
   logic adv;

   // tok: completed sum bits below group k, operand A bits from group k up.
   logic [NGRP-1:0]            vld_pipe_q, vld_pipe_d;
   logic [NGRP-1:0][WIDTH-1:0] tok_q, tok_d;
   logic [NGRP-1:0]            c_q, c_d;

   logic [NGRP-1:0][GROUP-1:0] gsum;
   logic [NGRP-1:0]            gcout;
   logic                       last_cmsb;
   logic [WIDTH-1:0]           b_in;

   assign stall    = vld_pipe_q[NGRP-1] & ~out_ready;
   assign adv      = ~stall;
   assign in_ready = ~stall;

   // Subtract is A + ~B + 1.
   assign b_in = (in_sub == MODE_ADD) ? in_b : ~in_b;

   for (genvar k = 0; k < NGRP; k++) begin : g_stage
      localparam int LO = k * GROUP;
      localparam int BW = WIDTH - LO;

      // Only the not-yet-consumed B bits are kept; group k sits at bit 0.
      logic [BW-1:0] b_q, b_d;

      if (k == 0) begin : g_b_first
         always_comb begin
            b_d = b_q;
            if (adv) b_d = b_in;
         end
      end else begin : g_b_next
         always_comb begin
            b_d = b_q;
            if (adv) b_d = g_stage[k-1].b_q[BW+GROUP-1:GROUP];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) b_q <= '0;
         else        b_q <= b_d;
      end

      if (k == NGRP - 1) begin : g_cla_last
         cla_group #(.W(GROUP)) u_cla (
            .a    (tok_q[k][LO +: GROUP]),
            .b    (b_q[GROUP-1:0]),
            .cin  (c_q[k]),
            .sum  (gsum[k]),
            .cout (gcout[k]),
            .cmsb (last_cmsb)
         );
      end else begin : g_cla_mid
         logic cmsb_unused;
         cla_group #(.W(GROUP)) u_cla (
            .a    (tok_q[k][LO +: GROUP]),
            .b    (b_q[GROUP-1:0]),
            .cin  (c_q[k]),
            .sum  (gsum[k]),
            .cout (gcout[k]),
            .cmsb (cmsb_unused)
         );
      end
   end

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      tok_d      = tok_q;
      c_d        = c_q;
      if (adv) begin
         vld_pipe_d[0] = in_valid;
         tok_d[0]      = in_a;
         c_d[0]        = (in_sub == MODE_SUB) ? 1'b1 : in_cin;
         for (int k = 1; k < NGRP; k++) begin
            vld_pipe_d[k]                    = vld_pipe_q[k-1];
            tok_d[k]                         = tok_q[k-1];
            tok_d[k][(k-1)*GROUP +: GROUP]   = gsum[k-1];
            c_d[k]                           = gcout[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         tok_q      <= '0;
         c_q        <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         tok_q      <= tok_d;
         c_q        <= c_d;
      end
   end

   // Last group is resolved combinationally from held registers, so the
   // outputs stay stable during a stall and read as zero out of reset.
   always_comb begin
      out_sum                               = tok_q[NGRP-1];
      out_sum[(NGRP-1)*GROUP +: GROUP]      = gsum[NGRP-1];
   end

   assign out_valid = vld_pipe_q[NGRP-1];
   assign out_cout  = gcout[NGRP-1];
   assign out_ovf   = last_cmsb ^ gcout[NGRP-1];

endmodule

// File: tb/tb_hybrid_adder_pipe.sv
module tb_hybrid_adder_pipe;

   localparam int W    = 16;
   localparam int G    = 4;
   localparam int NGRP = W / G;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready;
   logic [W-1:0] in_a, in_b;
   logic         in_cin, in_sub;
   logic         out_valid, out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout, out_ovf;

   hybrid_adder_pipe #(.WIDTH(W), .GROUP(G)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      int           t_acc;
      int           st_acc;
      bit           seen;
   } exp_t;

   typedef struct {
      logic [W-1:0] a, b;
      logic         cin, sub;
      logic [W-1:0] s;
      logic         co, ov;
   } vec_t;

   exp_t         sb[$];
   int           n_vec = 0;
   int           n_bad = 0;
   int           cyc = 0;
   int           stalls = 0;
   int           n_out = 0;
   logic [W-1:0] exp_s;
   logic         exp_co, exp_ov;
   bit           rnd_done;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Reference: plain wide add; overflow from operand/result signs.
   task automatic model(input logic [W-1:0] a, b, input logic cin, sub,
                        output logic [W-1:0] s, output logic co, ov);
      logic [W-1:0] bb;
      logic [W:0]   r;
      bb = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      s  = r[W-1:0];
      co = r[W];
      ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from state updates.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 1'b0, {15'd0, out_cout, out_ovf, out_sum}, 32'd0);
            end else begin
               chk("result", out_sum == sb[0].s && out_cout == sb[0].co && out_ovf == sb[0].ov,
                   {14'd0, out_cout, out_ovf, out_sum}, {14'd0, sb[0].co, sb[0].ov, sb[0].s});
               if (!sb[0].seen) begin
                  sb[0].seen = 1'b1;
                  chk("latency", (cyc - sb[0].t_acc) == (NGRP + stalls - sb[0].st_acc),
                      cyc - sb[0].t_acc, NGRP + stalls - sb[0].st_acc);
               end
               if (out_ready) begin
                  void'(sb.pop_front());
                  n_out++;
               end
            end
            if (!out_ready) stalls++;
         end
         if (in_valid && in_ready)
            sb.push_back('{exp_s, exp_co, exp_ov, cyc, stalls, 1'b0});
      end
   end

   // Presents one operation and holds it until accepted; leaves in_valid high.
   task automatic send(input logic [W-1:0] a, b, input logic cin, sub,
                       input logic [W-1:0] s, input logic co, ov);
      bit ok;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub;
      exp_s = s; exp_co = co; exp_ov = ov;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
      end
      if (!ok) chk("accept_timeout", 1'b0, 32'd0, 32'd1);
   endtask

   task automatic send_m(input logic [W-1:0] a, b, input logic cin, sub);
      logic [W-1:0] s;
      logic co, ov;
      model(a, b, cin, sub, s, co, ov);
      send(a, b, cin, sub, s, co, ov);
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(posedge clk); #2;
         done = (sb.size() == 0) && !out_valid;
      end
      chk("drain", done, sb.size(), 32'd0);
   endtask

   vec_t dir[10];
   int   n0;

   initial begin
      dir[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      dir[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      dir[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      dir[3] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
      dir[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      dir[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      dir[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      dir[7] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
      dir[8] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
      dir[9] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b1; exp_s = '0; exp_co = 1'b0; exp_ov = 1'b0; rnd_done = 1'b0;

      // Reset state
      #3;
      chk("rst_out_valid", out_valid == 1'b0, out_valid, 32'd0);
      chk("rst_out_sum",   out_sum == '0,     out_sum,   32'd0);
      chk("rst_cout_ovf",  {out_cout, out_ovf} == 2'b00, {out_cout, out_ovf}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_in_ready", in_ready == 1'b1, in_ready, 32'd1);

      // Directed vectors, issued back-to-back
      foreach (dir[i]) send(dir[i].a, dir[i].b, dir[i].cin, dir[i].sub, dir[i].s, dir[i].co, dir[i].ov);
      in_valid = 1'b0;
      wait_drain();

      // Eight back-to-back ops with a 3-cycle output stall mid-stream
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++) send_m(16'h1000 * i + 16'h0111, 16'h0F0F, i[0], i[1]);
            in_valid = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            chk("stall_in_ready", in_ready == 1'b0, in_ready, 32'd0);
            chk("stall_out_valid", out_valid == 1'b1, out_valid, 32'd1);
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();
      chk("stall_count", (n_out - n0) == 8, n_out - n0, 32'd8);

      // Reset with three tokens in flight
      send_m(16'h1111, 16'h2222, 1'b0, 1'b0);
      send_m(16'h3333, 16'h0001, 1'b0, 1'b1);
      send_m(16'hABCD, 16'h1111, 1'b1, 1'b0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_valid", out_valid == 1'b1, out_valid, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid == 1'b0, out_valid, 32'd0);
      chk("mid_rst_sum", out_sum == '0, out_sum, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("post_rst_in_ready", in_ready == 1'b1, in_ready, 32'd1);
      repeat (8) @(posedge clk);
      #2 chk("no_stale", out_valid == 1'b0, out_valid, 32'd0);
      send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      in_valid = 1'b0;
      wait_drain();

      // Random operations, both modes, random gaps and output back-pressure
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               if ($urandom_range(0, 7) == 0) begin
                  in_valid = 1'b0;
                  @(posedge clk); #1;
               end
               send_m(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            end
            in_valid = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
